// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) sequencing one shared 32-bit adder.
module claAdder32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);
  assign {c_out, sum} = {1'b0, x} + {1'b0, y} + {32'b0, c_in};
endmodule

module mul_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, CALC, NEG_LO, NEG_HI, DONE} state_t;
  state_t state;
  logic [31:0] mcand, hi, lo, x, y, sum;
  logic [4:0] cnt;
  logic [1:0] op_r;
  logic cneg, psign, c_in, c_out, sa, sb, nb;
  assign sa = (op == 2'b01 || op == 2'b10) && a[31];
  assign sb = op == 2'b01 && b[31];
  assign nb = op_r == 2'b01 && lo[31];
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  always_comb begin
    x = state == NEG_A ? ~mcand : (state == NEG_B || state == NEG_LO) ? ~lo :
        state == NEG_HI ? ~hi : state == CALC ? hi : 32'b0;
    y = (state == CALC && lo[0]) ? mcand : 32'b0;
    c_in = state == NEG_A || state == NEG_B || state == NEG_LO || (state == NEG_HI && cneg);
  end
  claAdder32 u_add (.x(x), .y(y), .c_in(c_in), .sum(sum), .c_out(c_out));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      op_r <= '0;
      cneg <= 1'b0;
      psign <= 1'b0;
      result <= '0;
    end else if (flush && busy) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          mcand <= a;
          lo <= b;
          hi <= '0;
          cnt <= '0;
          op_r <= op;
          psign <= sa ^ sb;
          state <= sa ? NEG_A : sb ? NEG_B : CALC;
        end
        NEG_A: begin
          mcand <= sum;
          state <= nb ? NEG_B : CALC;
        end
        NEG_B: begin
          lo <= sum;
          state <= CALC;
        end
        CALC: begin
          hi <= {c_out, sum[31:1]};
          lo <= {sum[0], lo[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= psign ? NEG_LO : DONE;
            if (!psign) result <= op_r == 2'b00 ? {sum[0], lo[31:1]} : {c_out, sum[31:1]};
          end
        end
        NEG_LO: begin
          lo <= sum;
          cneg <= c_out;
          state <= NEG_HI;
        end
        NEG_HI: begin
          hi <= sum;
          result <= op_r == 2'b00 ? lo : sum;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: randomized and directed checks of mul_seq_ctrl against an arithmetic product model.
module tb_mul_seq_ctrl;
  logic clk = 0, rst = 1, start = 0, flush = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, done;
  logic [31:0] result;
  int checks = 0, errors = 0;

  mul_seq_ctrl dut (.clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
                    .a(a), .b(b), .busy(busy), .done(done), .result(result));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ex, ey, p;
    ex = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
    ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
    p = ex * ey;
    return o == 2'b00 ? p[31:0] : p[63:32];
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int na, nb;
    na = ((o == 2'b01 || o == 2'b10) && x[31]) ? 1 : 0;
    nb = (o == 2'b01 && y[31]) ? 1 : 0;
    return 32 + na + nb + ((na ^ nb) != 0 ? 2 : 0);
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] r);
    int bad_busy = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
      if (!busy) bad_busy++;
    end
    r = result;
    checks++;
    if (bad_busy != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_window op=%0d got %0d idle cycles busy=%b, want 0 and busy=0", o, bad_busy, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse op=%0d done=%b want 0", o, done); end
  endtask

  task automatic check_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat;
    logic [31:0] r;
    run_op(o, x, y, lat, r);
    checks++;
    if (r !== ref_res(o, x, y)) begin
      errors++;
      $display("FAIL %s_result op=%0d a=%h b=%h got %h want %h", nm, o, x, y, r, ref_res(o, x, y));
    end
    checks++;
    if (lat != ref_lat(o, x, y)) begin
      errors++;
      $display("FAIL %s_latency op=%0d a=%h b=%h got %0d want %0d", nm, o, x, y, lat, ref_lat(o, x, y));
    end
  endtask

  task automatic test_reset();
    #3; rst = 1; #1;
    checks++;
    if (busy !== 0 || done !== 0 || result !== 0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b result=%h want 0 0 0", busy, done, result);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_directed();
    check_op("mul7x6", 2'b00, 32'd7, 32'd6);
    check_op("mulh_m1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_op("mul_m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_op("mulhsu", 2'b10, 32'hFFFFFFFE, 32'd3);
    check_op("mulh_min", 2'b01, 32'h80000000, 32'h80000000);
    check_op("mulhu_m1", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_op("mulh_min1", 2'b01, 32'h80000000, 32'd1);
    check_op("mulhsu_neg_b", 2'b10, 32'd5, 32'hFFFFFFFF);
    check_op("mulh_zero", 2'b01, 32'h0, 32'h80000000);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      check_op("rand", 2'($urandom_range(3)), $urandom, $urandom);
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    logic [31:0] want;
    want = ref_res(2'b11, 32'h12345678, 32'h9ABCDEF0);
    @(negedge clk);
    op = 2'b11; a = 32'h12345678; b = 32'h9ABCDEF0; start = 1;
    @(negedge clk); start = 0;
    repeat (9) @(negedge clk);
    op = 2'b00; a = 32'd2; b = 32'd2; start = 1;
    @(negedge clk); start = 0;
    for (int n = 0; n < 70; n++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        checks++;
        if (result !== want) begin errors++; $display("FAIL ignore_start_result got %h want %h", result, want); end
      end
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL ignore_start_dones got %0d want 1", dones); end
  endtask

  task automatic test_flush();
    int dones = 0;
    logic [31:0] prev;
    prev = result;
    @(negedge clk);
    op = 2'b00; a = 32'd1000; b = 32'd77; start = 1;
    @(posedge clk);
    @(negedge clk); start = 0;
    repeat (14) @(negedge clk);
    flush = 1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 0 || done !== 0) begin errors++; $display("FAIL flush_idle busy=%b done=%b want 0 0", busy, done); end
    @(negedge clk); flush = 0;
    for (int n = 0; n < 40; n++) begin @(posedge clk); #1; if (done) dones++; end
    checks++;
    if (dones != 0 || result !== prev) begin
      errors++;
      $display("FAIL flush_hold dones=%0d result=%h want 0 %h", dones, result, prev);
    end
    @(negedge clk); start = 1; flush = 1; op = 2'b00; a = 3; b = 4;
    @(posedge clk); #1;
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL start_flush busy=%b want 0", busy); end
    @(negedge clk); start = 0; flush = 0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    op = 2'b11; a = 32'hDEADBEEF; b = 32'hCAFEF00D; start = 1;
    @(negedge clk); start = 0;
    repeat (10) @(posedge clk);
    #2; rst = 1; #1;
    checks++;
    if (busy !== 0 || done !== 0 || result !== 0) begin
      errors++;
      $display("FAIL async_reset busy=%b done=%b result=%h want 0 0 0", busy, done, result);
    end
    @(negedge clk); rst = 0;
    check_op("after_reset", 2'b00, 32'd3, 32'd5);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
